// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared types and defaults for the 2D I/Q histogram front-end
package hist_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] i;
        logic signed [DATA_W_DEF-1:0] q;
    } iq_t;

endpackage

// File: rtl/hist2d_ctrl_if.sv
// rtl/hist2d_ctrl_if.sv - sample request bus and histogram engine bus
interface hist2d_ctrl_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32
);
    logic [N_CH-1:0]        req_valid;
    logic [N_CH-1:0]        req_ready;
    logic [N_CH*DATA_W-1:0] req_i;
    logic [N_CH*DATA_W-1:0] req_q;
    logic                   hist_data_in;
    logic signed [DATA_W-1:0] hist_i_val;
    logic signed [DATA_W-1:0] hist_q_val;
    logic                   hist_bin_found;

    modport master (
        output req_valid, req_i, req_q, hist_bin_found,
        input  req_ready, hist_data_in, hist_i_val, hist_q_val
    );

    modport slave (
        input  req_valid, req_i, req_q, hist_bin_found,
        output req_ready, hist_data_in, hist_i_val, hist_q_val
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant over N_CH requesters
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_CH-1:0]  req,
    input  logic             accept,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);
    // prio is the channel searched first, i.e. last grant + 1
    logic [IDX_W-1:0] prio;
    logic [IDX_W-1:0] c;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        c         = '0;
        for (int i = 0; i < N_CH; i++) begin
            c = IDX_W'((int'(prio) + i) % N_CH);
            if (!any && req[c]) begin
                any       = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = c;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio <= '0;
        end else if (accept) begin
            prio <= (grant_idx == IDX_W'(N_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end
endmodule

// File: rtl/hist2d_ctrl.sv
// rtl/hist2d_ctrl.sv - arbitrates channel samples into the histogram engine and counts a run
module hist2d_ctrl import hist_pkg::*; #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk100,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W-1:0]        num_data_pts,
    hist2d_ctrl_if.slave            bus,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic [$clog2(N_CH)-1:0] grant_id,
    output logic [CNT_W-1:0]        sample_count
);
    localparam int GID_W = $clog2(N_CH);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_t state, state_nx;
    logic [CNT_W-1:0] target;
    logic [TO_W-1:0]  tcnt;
    logic [N_CH-1:0]  grant;
    logic [GID_W-1:0] gidx;
    logic any, accept, tmo_hit, last_sample;
    logic signed [DATA_W-1:0] ch_i [N_CH];
    logic signed [DATA_W-1:0] ch_q [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign ch_i[k] = bus.req_i[k*DATA_W +: DATA_W];
        assign ch_q[k] = bus.req_q[k*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N_CH(N_CH), .IDX_W(GID_W)) u_arb (
        .clk       (clk100),
        .rstn      (rstn),
        .req       (bus.req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (gidx),
        .any       (any)
    );

    // bin_found on the expiring cycle is checked first, so it wins over the timeout
    assign tmo_hit     = (tcnt == TO_W'(TIMEOUT - 1));
    assign last_sample = (sample_count + CNT_W'(1)) == target;

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = (num_data_pts == '0) ? DONE : ARB;
            ARB:   if (any) begin
                       accept   = 1'b1;
                       state_nx = ISSUE;
                   end
            ISSUE: state_nx = WAIT;
            WAIT:  if (bus.hist_bin_found) state_nx = last_sample ? DONE : ARB;
                   else if (tmo_hit)       state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            accept   = 1'b0;
        end
        bus.req_ready    = accept ? grant : '0;
        bus.hist_data_in = (state == ISSUE);
        busy             = (state != IDLE);
        done             = (state == DONE) && !abort;
    end

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            target         <= '0;
            sample_count   <= '0;
            timeout_err    <= 1'b0;
            tcnt           <= '0;
            grant_id       <= '0;
            bus.hist_i_val <= '0;
            bus.hist_q_val <= '0;
        end else begin
            if (state == IDLE && start && !abort) begin
                target       <= num_data_pts;
                sample_count <= '0;
                timeout_err  <= 1'b0;
            end
            if (accept) begin
                bus.hist_i_val <= ch_i[gidx];
                bus.hist_q_val <= ch_q[gidx];
                grant_id       <= gidx;
            end
            if (state == ISSUE) tcnt <= '0;
            if (state == WAIT && !abort) begin
                if (bus.hist_bin_found) sample_count <= sample_count + CNT_W'(1);
                else if (tmo_hit)       timeout_err  <= 1'b1;
                else                    tcnt         <= tcnt + TO_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hist2d_ctrl.sv
// tb/tb_hist2d_ctrl.sv - directed bench with a transaction-level model of hist2d_ctrl
module tb_hist2d_ctrl;
    import hist_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int CW  = 16;
    localparam int TMO = 255;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
    logic [CW-1:0] num = '0;
    logic busy, done, timeout_err;
    logic [1:0] grant_id;
    logic [CW-1:0] sample_count;

    hist2d_ctrl_if #(.N_CH(N), .DATA_W(DW)) bus();

    hist2d_ctrl #(.N_CH(N), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk100       (clk),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .num_data_pts (num),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err),
        .grant_id     (grant_id),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // Producers: each channel presents samp[k][n] until it is accepted
    iq_t samp [N][16];
    int cnt_ch [N];
    logic [N-1:0] src_en = '0;
    logic src_clr = 1'b0;
    int src_len = 8;

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (src_clr)               cnt_ch[k] <= 0;
            else if (bus.req_ready[k]) cnt_ch[k] <= cnt_ch[k] + 1;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            bus.req_valid[k]       = src_en[k] && (cnt_ch[k] < src_len);
            bus.req_i[k*DW +: DW]  = samp[k][4'(cnt_ch[k])].i;
            bus.req_q[k*DW +: DW]  = samp[k][4'(cnt_ch[k])].q;
        end
    end

    // Histogram engine: bin_found resp_delay cycles after each strobe
    int resp_delay = 5;
    bit resp_en = 1'b0;
    int bf_total = 0;
    int last_bf_cyc = 0;

    initial begin
        int pend;
        pend = 0;
        bus.hist_bin_found = 1'b0;
        forever begin
            @(negedge clk);
            bus.hist_bin_found = 1'b0;
            if (!resp_en) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.hist_bin_found = 1'b1;
                        bf_total++;
                        last_bf_cyc = cyc;
                    end
                end
                if (bus.hist_data_in) pend = resp_delay;
            end
        end
    end

    // Model state and observation log
    typedef struct { int i; int q; int k; int c; } exp_t;
    exp_t eq[$];
    int glog[$];
    int ptr_m = 0, target_m = 0, bf_base = 0, start_cyc = 0;
    int n_accept = 0, n_strobe = 0, n_done = 0, done_cyc = 0, last_strobe_cyc = 0;

    initial begin
        int kexp, kact, got;
        bit tmo;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                ptr_m = 0;
                eq.delete();
            end else begin
                if (bus.req_ready != '0) begin
                    kexp = -1;
                    kact = -1;
                    for (int j = 0; j < N; j++) begin
                        if (kexp < 0 && bus.req_valid[2'((ptr_m + j) % N)]) kexp = (ptr_m + j) % N;
                        if (bus.req_ready[j]) kact = j;
                    end
                    chk("ready_onehot", $countones(bus.req_ready), 1);
                    chk("rr_grant", kact, kexp);
                    e.k = kact;
                    e.c = cyc;
                    e.i = samp[2'(kact)][4'(cnt_ch[2'(kact)])].i;
                    e.q = samp[2'(kact)][4'(cnt_ch[2'(kact)])].q;
                    eq.push_back(e);
                    ptr_m = (kact + 1) % N;
                    n_accept++;
                end
                if (bus.hist_data_in) begin
                    chk("strobe_pending", eq.size(), 1);
                    if (eq.size() > 0) begin
                        e = eq.pop_front();
                        chk("hist_i", bus.hist_i_val, e.i);
                        chk("hist_q", bus.hist_q_val, e.q);
                        chk("grant_id", grant_id, e.k);
                        chk("issue_latency", cyc - e.c, 1);
                    end
                    glog.push_back(int'(grant_id));
                    n_strobe++;
                    last_strobe_cyc = cyc;
                end
                if (done) begin
                    got = bf_total - bf_base;
                    tmo = got < target_m;
                    chk("done_count", sample_count, got);
                    chk("done_timeout", timeout_err, tmo);
                    if (tmo)                chk("done_lat_tmo", cyc - last_strobe_cyc, TMO + 1);
                    else if (target_m == 0) chk("done_lat_zero", cyc - start_cyc, 1);
                    else                    chk("done_lat", cyc - last_bf_cyc, 1);
                    n_done++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic setup_src(input logic [N-1:0] en);
        src_en  = en;
        src_clr = 1'b1;
        @(negedge clk);
        src_clr = 1'b0;
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start     = 1'b1;
        num       = CW'(n);
        target_m  = n;
        bf_base   = bf_total;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int b;
        b = 0;
        while (n_done < n && b < budget) begin
            @(negedge clk);
            #3;
            b++;
        end
        chk("wait_done", n_done, n);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int b;
        b = 0;
        while (n_strobe < n && b < budget) begin
            @(negedge clk);
            #3;
            b++;
        end
        chk("wait_strobe", n_strobe, n);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
        chk({tag, "_gid"}, grant_id, 0);
        chk({tag, "_count"}, sample_count, 0);
        chk({tag, "_strobe"}, bus.hist_data_in, 0);
        chk({tag, "_ready"}, bus.req_ready, 0);
        chk({tag, "_ival"}, bus.hist_i_val, 0);
        chk({tag, "_qval"}, bus.hist_q_val, 0);
    endtask

    int s0, d0, a0, g0;
    int exp_g [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 16; j++) begin
                samp[k][j].i = k * 16 + j - 3;
                samp[k][j].q = (k == 0) ? (k * 16 + j - 3) : -(k * 16 + j - 3);
            end
        end
        repeat (3) @(negedge clk);
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // fairness: all channels requesting
        setup_src(4'b1111);
        resp_en = 1'b1;
        resp_delay = 2;
        g0 = glog.size();
        d0 = n_done;
        do_start(8);
        wait_dones(d0 + 1, 300);
        for (int i = 0; i < 8; i++) chk("fair_grant", glog[g0 + i], exp_g[i]);
        chk("fair_count", sample_count, 8);

        // single channel, engine answers 5 cycles after each strobe
        setup_src(4'b0001);
        resp_delay = 5;
        s0 = n_strobe;
        d0 = n_done;
        do_start(3);
        wait_dones(d0 + 1, 200);
        chk("single_strobes", n_strobe - s0, 3);
        chk("single_count", sample_count, 3);
        chk("single_last_i", bus.hist_i_val, -1);
        chk("single_last_q", bus.hist_q_val, -1);
        chk("single_done_lat", done_cyc - last_bf_cyc, 1);
        chk("single_tmo", timeout_err, 0);

        // engine never answers
        setup_src(4'b0010);
        resp_en = 1'b0;
        s0 = n_strobe;
        d0 = n_done;
        do_start(5);
        wait_dones(d0 + 1, 600);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_count", sample_count, 0);
        chk("tmo_strobes", n_strobe - s0, 1);
        chk("tmo_done_lat", done_cyc - last_strobe_cyc, 256);

        // zero-length run
        setup_src(4'b0000);
        resp_en = 1'b1;
        a0 = n_accept;
        s0 = n_strobe;
        d0 = n_done;
        do_start(0);
        wait_dones(d0 + 1, 20);
        chk("zero_tmo_cleared", timeout_err, 0);
        chk("zero_done_lat", done_cyc - start_cyc, 1);
        chk("zero_accepts", n_accept - a0, 0);
        chk("zero_strobes", n_strobe - s0, 0);

        // abort in WAIT after two completed samples
        setup_src(4'b0100);
        resp_delay = 3;
        s0 = n_strobe;
        d0 = n_done;
        do_start(5);
        wait_strobes(s0 + 3, 100);
        @(negedge clk);
        abort = 1'b1;
        resp_en = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        #3;
        chk("abort_busy", busy, 0);
        chk("abort_count", sample_count, 2);
        chk("abort_no_done", n_done, d0);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        num = CW'(5);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #3;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_count", sample_count, 2);
        resp_en = 1'b1;
        d0 = n_done;
        do_start(5);
        #3;
        chk("restart_cleared", sample_count, 0);
        wait_dones(d0 + 1, 200);
        chk("restart_count", sample_count, 5);

        // asynchronous reset during ISSUE
        setup_src(4'b1111);
        resp_delay = 2;
        s0 = n_strobe;
        do_start(6);
        wait_strobes(s0 + 2, 100);
        chk("pre_reset_strobe", bus.hist_data_in, 1);
        rstn = 1'b0;
        #1;
        chk_all_zero("midreset");
        resp_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        setup_src(4'b1111);
        resp_en = 1'b1;
        g0 = glog.size();
        d0 = n_done;
        do_start(2);
        wait_dones(d0 + 1, 100);
        chk("post_reset_first_grant", glog[g0], 0);
        chk("post_reset_count", sample_count, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
